// File: rtl/hex_display_ctrl_pkg.sv
// rtl/hex_display_ctrl_pkg.sv - shared segment widths, glyph table and polarity helper
package hex_display_ctrl_pkg;

  localparam int SEG_W = 7;

  // Glyphs are stored active-low, bit order g..a
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b0000011;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b1000110;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b0100001;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  function automatic logic [SEG_W-1:0] glyph_lookup(input logic [3:0] nib);
    case (nib)
      4'h0: return GLYPH_0;
      4'h1: return GLYPH_1;
      4'h2: return GLYPH_2;
      4'h3: return GLYPH_3;
      4'h4: return GLYPH_4;
      4'h5: return GLYPH_5;
      4'h6: return GLYPH_6;
      4'h7: return GLYPH_7;
      4'h8: return GLYPH_8;
      4'h9: return GLYPH_9;
      4'hA: return GLYPH_A;
      4'hB: return GLYPH_B;
      4'hC: return GLYPH_C;
      4'hD: return GLYPH_D;
      4'hE: return GLYPH_E;
      default: return GLYPH_F;
    endcase
  endfunction

  function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] glyph_al,
                                                    input bit active_low);
    return active_low ? glyph_al : ~glyph_al;
  endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// rtl/hex_seg_lut.sv - combinational nibble-to-glyph lookup with blank override (active-low)
module hex_seg_lut
  import hex_display_ctrl_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             blank,
  output logic [SEG_W-1:0] glyph
);

  always_comb begin
    glyph = blank ? SEG_BLANK : glyph_lookup(nibble);
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - registered seven-segment bank driver with blanking and blink
module hex_display_ctrl
  import hex_display_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        load,
  input  logic [4*NUM_DIGITS-1:0]     data_in,
  input  logic                        lz_blank,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic                        enable,
  output logic                        load_ack,
  output logic [SEG_W*NUM_DIGITS-1:0] seg_out
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int SW    = SEG_W * NUM_DIGITS;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [SW-1:0]    SEG_OFF  = ACTIVE_LOW ? {SW{1'b1}} : {SW{1'b0}};

  logic [DW-1:0]    data_q, data_d;
  logic             loaded_q, loaded_d;
  logic             load_ack_q, load_ack_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [SW-1:0]    seg_q, seg_d;

  logic [NUM_DIGITS-1:0]            nz_above;
  logic [NUM_DIGITS-1:0]            digit_blank;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] glyph_al;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data_q        <= '0;
      loaded_q      <= 1'b0;
      load_ack_q    <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      seg_q         <= SEG_OFF;
    end else begin
      data_q        <= data_d;
      loaded_q      <= loaded_d;
      load_ack_q    <= load_ack_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
    end
  end

  // loaded_q keeps the pins dark after reset until real data has been captured
  always_comb begin
    data_d     = load ? data_in : data_q;
    loaded_d   = loaded_q | load;
    load_ack_d = load;
    if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + CNT_W'(1);
      blink_phase_d = blink_phase_q;
    end
  end

  // nz_above[i]: some nibble from i up to the MSD is non-zero
  always_comb begin
    nz_above = '0;
    nz_above[NUM_DIGITS-1] = |data_q[DW-1 -: 4];
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      nz_above[i] = nz_above[i+1] | (|data_q[4*i +: 4]);
    end
  end

  always_comb begin
    digit_blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_blank[i] = !enable || !loaded_q
                    || (blink_mask[i] && !blink_phase_q)
                    || (lz_blank && (i != 0) && !nz_above[i]);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_seg_lut u_lut (
      .nibble (data_q[4*g +: 4]),
      .blank  (digit_blank[g]),
      .glyph  (glyph_al[g])
    );
  end

  always_comb begin
    seg_d = SEG_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_d[SEG_W*i +: SEG_W] = seg_polarity(glyph_al[i], ACTIVE_LOW);
    end
  end

  assign load_ack = load_ack_q;
  assign seg_out  = seg_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - scoreboard bench for hex_display_ctrl (active-low and active-high copies)
module tb_hex_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [41:0] ALL1 = {42{1'b1}};
  localparam logic [41:0] ALL0 = '0;

  logic        clk = 1'b0;
  logic        clrn, load, lz_blank, enable;
  logic [23:0] data_in;
  logic [5:0]  blink_mask;
  logic        load_ack, ack_alt;
  logic [41:0] seg_out, seg_alt;

  hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .clrn(clrn), .load(load), .data_in(data_in), .lz_blank(lz_blank),
    .blink_mask(blink_mask), .enable(enable), .load_ack(load_ack), .seg_out(seg_out)
  );

  hex_display_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4), .ACTIVE_LOW(1'b0)) dut_alt (
    .clk(clk), .clrn(clrn), .load(load), .data_in(data_in), .lz_blank(lz_blank),
    .blink_mask(blink_mask), .enable(enable), .load_ack(ack_alt), .seg_out(seg_alt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    int          kind;
    logic [41:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   rel = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [41:0] d6(input logic [6:0] a5, a4, a3, a2, a1, a0);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  // digit 0 under blink: phase counted from the last reset release, BLINK_DIV=4
  function automatic bit is_blank(input int c);
    return (((c - 1 - rel) / 4) % 2) == 1;
  endfunction

  task automatic check(input string nm, input logic [41:0] act, input logic [41:0] exp, input bit on_time);
    n_chk++;
    if (on_time && act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h on_time=%0d", nm, cyc, act, exp, on_time);
  endtask

  task automatic push(input int at, input int kind, input logic [41:0] v, input string nm);
    exp_t e;
    e.at = at; e.kind = kind; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [23:0] d);
    load = 1'b1;
    data_in = d;
    step(1);
    load = 1'b0;
  endtask

  // Monitor: compares every expectation whose cycle has arrived
  always @(negedge clk) begin
    logic [41:0] act;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].at <= cyc) begin
        case (sb[k].kind)
          0:       act = seg_out;
          1:       act = {41'b0, load_ack};
          default: act = seg_alt;
        endcase
        check(sb[k].name, act, sb[k].val, sb[k].at == cyc);
        sb.delete(k);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    bit reloaded;
    clrn = 1'b0; load = 1'b1; data_in = 24'h123456;
    enable = 1'b1; lz_blank = 1'b0; blink_mask = '0;
    step(2);
    push(cyc + 1, 0, ALL1, "rst_seg");
    push(cyc + 1, 1, 42'd0, "rst_ack");
    push(cyc + 1, 2, ALL0, "rst_seg_alt");
    step(2);

    clrn = 1'b1; load = 1'b0; rel = cyc;
    push(rel + 1, 0, ALL1, "post_rst_seg1");
    push(rel + 2, 0, ALL1, "post_rst_seg2");
    push(rel + 2, 1, 42'd0, "post_rst_ack");
    step(2);

    t = cyc;
    push(t + 1, 1, 42'd1, "ack_pulse");
    push(t + 2, 1, 42'd0, "ack_drop");
    push(t + 1, 0, ALL1, "load_latency");
    push(t + 2, 0, d6(SC, S0, SF, SF, SE, SE), "c0ffee");
    do_load(24'hC0FFEE);
    step(2);

    t = cyc;
    push(t + 2, 0, d6(S0, S0, S0, S1, S0, S2), "no_lz_102");
    do_load(24'h000102);
    step(2);

    t = cyc;
    push(t + 1, 1, 42'd1, "held_ack1");
    push(t + 2, 1, 42'd1, "held_ack2");
    push(t + 3, 1, 42'd0, "held_ack_drop");
    push(t + 2, 0, d6(S0, S0, S0, S0, S0, S1), "held_first");
    push(t + 3, 0, d6(S0, S0, S0, S1, S0, S2), "held_second");
    load = 1'b1; data_in = 24'h000001;
    step(1);
    data_in = 24'h000102;
    step(1);
    load = 1'b0;
    step(2);

    lz_blank = 1'b1;
    t = cyc;
    push(t + 1, 0, d6(SB, SB, SB, S1, S0, S2), "lz_102");
    step(2);

    t = cyc;
    push(t + 2, 0, d6(SB, SB, SB, SB, SB, S0), "lz_zero");
    push(t + 2, 2, d6(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'b0111111), "alt_zero");
    do_load(24'h000000);
    step(2);

    t = cyc;
    push(t + 2, 0, d6(SB, SB, SB, SB, SB, S8), "lz_8");
    push(t + 2, 2, d6(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'b1111111), "alt_8");
    do_load(24'h000008);
    step(2);

    enable = 1'b0;
    push(cyc + 1, 0, ALL1, "enable_off");
    push(cyc + 1, 2, ALL0, "enable_off_alt");
    step(1);
    enable = 1'b1;
    push(cyc + 1, 0, d6(SB, SB, SB, SB, SB, S8), "enable_on");
    push(cyc + 1, 2, d6(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'b1111111), "enable_on_alt");
    step(2);

    lz_blank = 1'b0; blink_mask = 6'b000001;
    t = cyc;
    do_load(24'h111111);
    for (int c = t + 2; c <= t + 25; c++)
      push(c, 0, d6(S1, S1, S1, S1, S1, is_blank(c) ? SB : S1), "blink");
    reloaded = 1'b0;
    while (cyc < t + 25) begin
      if (!reloaded && cyc >= t + 2 && is_blank(cyc + 1) && is_blank(cyc + 2)) begin
        push(cyc + 1, 1, 42'd1, "reload_in_blank_ack");
        load = 1'b1;
        step(1);
        load = 1'b0;
        reloaded = 1'b1;
      end else begin
        step(1);
      end
    end

    #2 clrn = 1'b0;
    #1;
    check("async_rst_seg", seg_out, ALL1, 1'b1);
    check("async_rst_seg_alt", seg_alt, ALL0, 1'b1);
    @(negedge clk);
    clrn = 1'b1; rel = cyc;
    push(rel + 1, 0, ALL1, "rst_no_data1");
    push(rel + 2, 0, ALL1, "rst_no_data2");
    step(1);
    do_load(24'h111111);
    for (int c = rel + 3; c <= rel + 14; c++)
      push(c, 0, d6(S1, S1, S1, S1, S1, is_blank(c) ? SB : S1), "blink_restart");
    step(13);

    step(2);
    while (sb.size() > 0) begin
      check({"leftover_", sb[0].name}, 42'd0, sb[0].val, 1'b0);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
